// File: rtl/db_ram_2p_bank.sv
// Simple-dual-port banked RAM with per-lane write masks, 1- or 2-cycle read latency and a
// clear sequencer. Optional macro DB_RAM_BYPASS_EN selects write-first same-address reads.
module db_ram_2p_bank #(
  parameter int unsigned Word_Width = 128,
  parameter int unsigned Addr_Width = 8,
  parameter int unsigned Bank_Num   = 4,
  parameter int unsigned Rd_Lat     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  output logic                  busy_o,
  input  logic                  wcen_i,
  input  logic [Bank_Num-1:0]   wmask_i,
  input  logic [Addr_Width-1:0] waddr_i,
  input  logic [Word_Width-1:0] wdata_i,
  input  logic                  rcen_i,
  input  logic [Addr_Width-1:0] raddr_i,
  output logic [Word_Width-1:0] rdata_o,
  output logic                  rvalid_o
);

  localparam int unsigned LaneW = Word_Width / Bank_Num;
  localparam int unsigned Depth = 2 ** Addr_Width;

  if (((Word_Width % Bank_Num) != 0) || ((Rd_Lat != 1) && (Rd_Lat != 2))) begin : g_param_err
    $error("db_ram_2p_bank: illegal parameters (Word_Width %% Bank_Num != 0 or Rd_Lat not 1/2)");
  end

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e                state_q, state_d;
  logic [Addr_Width-1:0] cnt_q, cnt_d;
  logic [Word_Width-1:0] mem [Depth];
  logic                  idle, wr_en, rd_en;
  logic [Word_Width-1:0] rd_word;
  logic                  s1_valid_q;
  logic [Word_Width-1:0] s1_data_q;

  assign idle   = (state_q == StIdle);
  assign busy_o = ~idle;
  assign wr_en  = idle & ~wcen_i;
  assign rd_en  = idle & ~rcen_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StIdle;
      end
      StIdle: begin
        if (clr_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage has no reset; the clear sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!idle) begin
        mem[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int k = 0; k < Bank_Num; k++) begin
          if (!wmask_i[k]) mem[waddr_i][k*LaneW +: LaneW] <= wdata_i[k*LaneW +: LaneW];
        end
      end
    end
  end

  always_comb begin
    rd_word = mem[raddr_i];
`ifdef DB_RAM_BYPASS_EN
    for (int k = 0; k < Bank_Num; k++) begin
      if (wr_en && (waddr_i == raddr_i) && !wmask_i[k]) begin
        rd_word[k*LaneW +: LaneW] = wdata_i[k*LaneW +: LaneW];
      end
    end
`endif
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) s1_data_q <= rd_word;
    end
  end

  if (Rd_Lat == 2) begin : g_lat2
    logic                  s2_valid_q;
    logic [Word_Width-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rvalid_o = s2_valid_q;
    assign rdata_o  = s2_data_q;
  end else begin : g_lat1
    assign rvalid_o = s1_valid_q;
    assign rdata_o  = s1_data_q;
  end

endmodule
